// File: rtl/tb_sequencer.sv
// rtl/tb_sequencer.sv - run controller: register slave plus clear/run/drain/done sequencing
module tb_sequencer #(
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       slave_address,
  input  logic             slave_read,
  input  logic             slave_write,
  input  logic [WIDTH-1:0] slave_writedata,
  output logic [WIDTH-1:0] slave_readdata,
  output logic             o_tb_enable,
  output logic             o_tb_clear,
  output logic [WIDTH-1:0] o_seed,
  input  logic [7:0]       i_event_ctr,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_next;
  logic [23:0]      len_reg;
  logic [WIDTH-1:0] seed_reg;
  logic             stop_on_event;
  logic [23:0]      run_ctr;
  logic [23:0]      executed;
  logic [7:0]       drain_ctr;
  logic             aborted;
  logic             event_stop;
  logic [WIDTH-1:0] status_word;

  logic wr_en, rd_en, ctrl_wr, start_req, abort_req, start_go;
  logic busy_state, run_last, event_hit;

  // A simultaneous read and write is treated as a bus error and ignored on both sides.
  assign wr_en      = slave_write & ~slave_read;
  assign rd_en      = slave_read & ~slave_write;
  assign ctrl_wr    = wr_en && (slave_address == 4'h0);
  assign abort_req  = ctrl_wr && slave_writedata[1];
  assign start_req  = ctrl_wr && slave_writedata[0] && !slave_writedata[1];
  assign start_go   = start_req && ((state == S_IDLE) || (state == S_DONE));
  assign busy_state = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
  assign run_last   = (run_ctr == 24'd1);
  assign event_hit  = stop_on_event && (i_event_ctr != 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start_go) state_next = S_CLEAR;
      S_CLEAR:        state_next = (abort_req || (len_reg == 24'd0)) ? S_DRAIN : S_RUN;
      S_RUN:          if (run_last || abort_req || event_hit) state_next = S_DRAIN;
      S_DRAIN:        if (drain_ctr == 8'(DRAIN_CYCLES - 1)) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Outputs are flops fed from the next-state decode so they align with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tb_enable <= 1'b0;
      o_tb_clear  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_seed      <= '0;
    end else begin
      o_tb_enable <= (state_next == S_RUN);
      o_tb_clear  <= (state_next == S_CLEAR);
      o_busy      <= (state_next == S_CLEAR) || (state_next == S_RUN) || (state_next == S_DRAIN);
      o_done      <= (state_next == S_DONE);
      if (start_go) o_seed <= seed_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_reg       <= '0;
      seed_reg      <= '0;
      stop_on_event <= 1'b0;
    end else if (wr_en && !busy_state) begin
      case (slave_address)
        4'h0:    stop_on_event <= slave_writedata[2];
        4'h4:    len_reg       <= slave_writedata[23:0];
        4'h8:    seed_reg      <= slave_writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_ctr   <= '0;
      drain_ctr <= '0;
    end else begin
      if (state == S_CLEAR)    run_ctr <= len_reg;
      else if (state == S_RUN) run_ctr <= run_ctr - 24'd1;
      drain_ctr <= (state == S_DRAIN) ? drain_ctr + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      executed   <= '0;
      aborted    <= 1'b0;
      event_stop <= 1'b0;
    end else if (start_go) begin
      executed   <= '0;
      aborted    <= 1'b0;
      event_stop <= 1'b0;
    end else if (state == S_CLEAR) begin
      if (abort_req) begin
        aborted  <= 1'b1;
        executed <= '0;
      end
    end else if (state == S_RUN) begin
      // Every RUN cycle had enable high, including the one on which the run exits.
      if (executed != 24'hFF_FFFF) executed <= executed + 24'd1;
      if (abort_req) aborted    <= 1'b1;
      if (event_hit) event_stop <= 1'b1;
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[0]    = o_busy;
    status_word[1]    = o_done;
    status_word[2]    = aborted;
    status_word[3]    = event_stop;
    status_word[31:8] = executed;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slave_readdata <= '0;
    end else if (rd_en) begin
      case (slave_address)
        4'h4:    slave_readdata <= {{(WIDTH-24){1'b0}}, len_reg};
        4'h8:    slave_readdata <= seed_reg;
        4'hC:    slave_readdata <= status_word;
        default: slave_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_sequencer.sv
// tb/tb_tb_sequencer.sv - self-checking bench for tb_sequencer with a read-data scoreboard
module tb_tb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        o_tb_enable;
  logic        o_tb_clear;
  logic [31:0] o_seed;
  logic [7:0]  i_event_ctr;
  logic        o_busy;
  logic        o_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  int en_cnt, clr_cnt, drain_cnt;
  logic [31:0] seed_seen;

  tb_sequencer #(.WIDTH(32), .DRAIN_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .slave_address   (slave_address),
    .slave_read      (slave_read),
    .slave_write     (slave_write),
    .slave_writedata (slave_writedata),
    .slave_readdata  (slave_readdata),
    .o_tb_enable     (o_tb_enable),
    .o_tb_clear      (o_tb_clear),
    .o_seed          (o_seed),
    .i_event_ctr     (i_event_ctr),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    slave_address   = addr;
    slave_writedata = data;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  // Expected value is queued when the read is issued and retired when readdata is valid.
  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    slave_address = addr;
    slave_read    = 1'b1;
    @(negedge clk);
    slave_read    = 1'b0;
    chk(tag_q.pop_front(), slave_readdata, exp_q.pop_front());
  endtask

  task automatic watch(input int abort_at, input int event_at);
    int cycles;
    bit fired;
    cycles = 0; fired = 0;
    en_cnt = 0; clr_cnt = 0; drain_cnt = 0; seed_seen = '0;
    while (!o_done && cycles < 3000) begin
      slave_write = 1'b0;
      if (o_tb_clear) begin
        clr_cnt++;
        seed_seen = o_seed;
      end
      if (o_tb_enable) en_cnt++;
      else if (o_busy && !o_tb_clear) drain_cnt++;
      if (abort_at > 0 && en_cnt == abort_at && !fired) begin
        fired           = 1;
        slave_address   = 4'h0;
        slave_writedata = 32'h2;
        slave_write     = 1'b1;
      end
      if (event_at > 0 && en_cnt == event_at) i_event_ctr = 8'd1;
      @(negedge clk);
      cycles++;
    end
    slave_write = 1'b0;
    chk("run_completes", {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    slave_address = '0; slave_read = 0; slave_write = 0; slave_writedata = '0;
    i_event_ctr = '0;
    repeat (2) @(negedge clk);
    chk("rst_readdata", slave_readdata, 32'd0);
    chk("rst_outputs", {28'd0, o_tb_enable, o_tb_clear, o_busy, o_done}, 32'd0);
    chk("rst_seed", o_seed, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    rd("rst_ctrl", 4'h0, 32'd0);
    rd("rst_len", 4'h4, 32'd0);
    rd("rst_seed_reg", 4'h8, 32'd0);
    rd("rst_status", 4'hC, 32'd0);

    wr(4'h4, 32'd10);
    wr(4'h8, 32'h0000_FFFF);
    rd("len_rb", 4'h4, 32'd10);
    rd("unmapped", 4'h2, 32'd0);
    wr(4'h0, 32'h1);
    chk("clear_busy", {31'd0, o_busy}, 32'd1);
    watch(0, 0);
    chk("l10_clear", clr_cnt, 1);
    chk("l10_seed", seed_seen, 32'h0000_FFFF);
    chk("l10_enable", en_cnt, 10);
    chk("l10_drain", drain_cnt, 4);
    rd("l10_status", 4'hC, 32'h0000_0A02);

    wr(4'h4, 32'd0);
    wr(4'h0, 32'h1);
    watch(0, 0);
    chk("l0_clear", clr_cnt, 1);
    chk("l0_enable", en_cnt, 0);
    chk("l0_drain", drain_cnt, 4);
    rd("l0_status", 4'hC, 32'h0000_0002);

    wr(4'h4, 32'd1000);
    wr(4'h0, 32'h5);
    watch(0, 37);
    i_event_ctr = 8'd0;
    chk("ev_enable", en_cnt, 37);
    chk("ev_drain", drain_cnt, 4);
    rd("ev_status", 4'hC, 32'h0000_250A);

    wr(4'h4, 32'd100);
    wr(4'h0, 32'h1);
    watch(20, 0);
    chk("ab_enable", en_cnt, 20);
    chk("ab_drain", drain_cnt, 4);
    rd("ab_status", 4'hC, 32'h0000_1406);
    wr(4'h0, 32'h3);
    chk("startabort_idle", {30'd0, o_busy, o_done}, 32'd1);
    rd("startabort_status", 4'hC, 32'h0000_1406);

    slave_address = 4'h4; slave_writedata = 32'd55; slave_read = 1'b1; slave_write = 1'b1;
    @(negedge clk);
    slave_read = 1'b0; slave_write = 1'b0;
    chk("rw_conflict_data", slave_readdata, 32'h0000_1406);
    rd("rw_conflict_len", 4'h4, 32'd100);

    wr(4'h4, 32'd50);
    wr(4'h0, 32'h1);
    repeat (10) @(negedge clk);
    chk("pre_reset_enable", {31'd0, o_tb_enable}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_enable", {31'd0, o_tb_enable}, 32'd0);
    chk("async_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd("post_reset_status", 4'hC, 32'd0);
    rd("post_reset_len", 4'h4, 32'd0);

    wr(4'h8, 32'hA5A5_0001);
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    wr(4'h4, 32'd77);
    wr(4'h8, 32'h1234_5678);
    wr(4'h0, 32'h1);
    watch(0, 0);
    rd("busy_len", 4'h4, 32'd10);
    rd("busy_seed", 4'h8, 32'hA5A5_0001);
    rd("busy_status", 4'hC, 32'h0000_0A02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
